setn_bank_sequencer: RTL and testbench



---
 rtl/setn_seq_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/setn_bank_sequencer.sv | 149 ++++++++++++++
 tb/tb_setn_bank_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/setn_seq_pkg.sv
// rtl/setn_seq_pkg.sv - shared state type and elaboration helpers for the setn bank sequencer
package setn_seq_pkg;

    typedef enum logic [1:0] {
        STARTUP = 2'd0,
        IDLE    = 2'd1,
        PULSE   = 2'd2,
        RECOVER = 2'd3
    } seq_state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic bit params_ok(input int nb, input int pw, input int rw, input int sw);
        return (nb >= 2) && (nb <= 16) && (pw >= 1) && (rw >= 0) && (sw >= 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of one requester
// Ports:
//   req     : request vector, one bit per bank
//   ptr     : highest-priority index for this pick
//   gnt     : one-hot grant (all zero when nothing requests)
//   gnt_idx : encoded index of the granted bank
//   any     : at least one request present
module rr_arbiter
    import setn_seq_pkg::*;
#(
    parameter int NB = 4,
    parameter int IW = 2
) (
    input  logic [NB-1:0] req,
    input  logic [IW-1:0] ptr,
    output logic [NB-1:0] gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    // One extra bit so ptr + i can be compared against NB before wrapping.
    logic [IW:0] pos;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        pos     = '0;
        for (int i = 0; i < NB; i++) begin
            pos = {1'b0, ptr} + (IW + 1)'(i);
            if (pos >= (IW + 1)'(NB)) begin
                pos = pos - (IW + 1)'(NB);
            end
            if (!any && req[pos[IW-1:0]]) begin
                any               = 1'b1;
                gnt_idx           = pos[IW-1:0];
                gnt[pos[IW-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/setn_bank_sequencer.sv
// rtl/setn_bank_sequencer.sv - staggered start-up release and round-robin set pulses for SETN banks
// Ports:
//   CLK       : clock, rising edge
//   RN        : asynchronous active-low reset
//   REQ       : per-bank set request, level, held until GNT
//   SETN_BANK : active-low set per bank, registered
//   GNT       : one-hot pulse on the first cycle of a bank's set pulse
//   BUSY      : high in every state except IDLE
//   DONE      : pulse on the final recovery cycle (final pulse cycle when RW = 0)
module setn_bank_sequencer
    import setn_seq_pkg::*;
#(
    parameter int NB = 4,
    parameter int PW = 3,
    parameter int RW = 2,
    parameter int SW = 2
) (
    input  logic          CLK,
    input  logic          RN,
    input  logic [NB-1:0] REQ,
    output logic [NB-1:0] SETN_BANK,
    output logic [NB-1:0] GNT,
    output logic          BUSY,
    output logic          DONE
);

    localparam int IW = clog2(NB);
    localparam int CW = clog2(max3(PW, RW, SW) + 1);

    // Terminal counts; the *_PRE values mark the cycle before the last one so
    // DONE can be registered and still land on the final cycle.
    localparam logic [CW-1:0] PW_LAST  = CW'(PW - 1);
    localparam logic [CW-1:0] PW_PRE   = CW'((PW >= 2) ? PW - 2 : 0);
    localparam logic [CW-1:0] RW_LAST  = CW'((RW >= 1) ? RW - 1 : 0);
    localparam logic [CW-1:0] RW_PRE   = CW'((RW >= 2) ? RW - 2 : 0);
    localparam logic [CW-1:0] SW_LAST  = CW'(SW - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NB - 1);

    if (!params_ok(NB, PW, RW, SW)) begin : g_param_check
        $error("setn_bank_sequencer: illegal NB/PW/RW/SW");
    end

    seq_state_t    state;
    logic [IW-1:0] idx;
    logic [IW-1:0] ptr;
    logic [IW-1:0] cur;
    logic [CW-1:0] cnt;

    logic [NB-1:0] arb_gnt;
    logic [IW-1:0] arb_idx;
    logic          arb_any;
    logic [IW-1:0] ptr_next;
    logic          done_next;

    rr_arbiter #(
        .NB(NB),
        .IW(IW)
    ) u_arb (
        .req     (REQ),
        .ptr     (ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    // Pointer moves past the granted bank so it is served last next time.
    assign ptr_next = (arb_idx == IDX_LAST) ? '0 : arb_idx + IW'(1);

    always_comb begin
        done_next = 1'b0;
        case (state)
            IDLE:    done_next = arb_any && (PW == 1) && (RW == 0);
            PULSE:   done_next = (RW == 0) ? ((PW >= 2) && (cnt == PW_PRE))
                                           : ((RW == 1) && (cnt == PW_LAST));
            RECOVER: done_next = (RW >= 2) && (cnt == RW_PRE);
            default: done_next = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state     <= STARTUP;
            idx       <= '0;
            ptr       <= '0;
            cur       <= '0;
            cnt       <= '0;
            SETN_BANK <= '0;
            GNT       <= '0;
            BUSY      <= 1'b1;
            DONE      <= 1'b0;
        end else begin
            GNT  <= '0;
            DONE <= done_next;
            case (state)
                STARTUP: begin
                    if (cnt == SW_LAST) begin
                        SETN_BANK[idx] <= 1'b1;
                        cnt            <= '0;
                        if (idx == IDX_LAST) begin
                            idx   <= '0;
                            state <= IDLE;
                            BUSY  <= 1'b0;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                IDLE: begin
                    if (arb_any) begin
                        GNT                <= arb_gnt;
                        SETN_BANK[arb_idx] <= 1'b0;
                        cur                <= arb_idx;
                        ptr                <= ptr_next;
                        cnt                <= '0;
                        state              <= PULSE;
                        BUSY               <= 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt == PW_LAST) begin
                        SETN_BANK[cur] <= 1'b1;
                        cnt            <= '0;
                        if (RW == 0) begin
                            state <= IDLE;
                            BUSY  <= 1'b0;
                        end else begin
                            state <= RECOVER;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RECOVER: begin
                    if (cnt == RW_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= STARTUP;
            endcase
        end
    end

endmodule

// File: tb/tb_setn_bank_sequencer.sv
// tb/tb_setn_bank_sequencer.sv - scoreboard bench for setn_bank_sequencer (RW=2 and RW=0 instances)
module tb_setn_bank_sequencer;

    localparam int NB   = 4;
    localparam int PW   = 3;
    localparam int SW   = 2;
    localparam int RW_A = 2;
    localparam int RW_B = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    rn;
    logic [NB-1:0] req     [2];
    logic [NB-1:0] setn_o  [2];
    logic [NB-1:0] gnt_o   [2];
    logic [1:0]    busy_o;
    logic [1:0]    done_o;

    logic [NB-1:0] dir_req [2];
    logic [1:0]    mode;

    int checks = 0;
    int errors = 0;

    // reference model state
    int            t_m     [2];
    int            tg_m    [2];
    int            g_m     [2];
    int            ptr_m   [2];
    int            next_ok [2];
    bit            has_m   [2];
    int            mgnts   [2];
    logic [NB-1:0] exp_setn[2];
    bit            exp_busy[2];
    bit            exp_done[2];
    int            q_a[$];
    int            q_b[$];

    int gnts  [2];
    int dones [2];
    int b1_gnts;

    setn_bank_sequencer #(.NB(NB), .PW(PW), .RW(RW_A), .SW(SW)) dut_a (
        .CLK(clk), .RN(rn[0]), .REQ(req[0]), .SETN_BANK(setn_o[0]),
        .GNT(gnt_o[0]), .BUSY(busy_o[0]), .DONE(done_o[0])
    );

    setn_bank_sequencer #(.NB(NB), .PW(PW), .RW(RW_B), .SW(SW)) dut_b (
        .CLK(clk), .RN(rn[1]), .REQ(req[1]), .SETN_BANK(setn_o[1]),
        .GNT(gnt_o[1]), .BUSY(busy_o[1]), .DONE(done_o[1])
    );

    function automatic int rw_of(input int i);
        return (i == 0) ? RW_A : RW_B;
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0d: got 0x%0h expected 0x%0h", name, i, t_m[i], got, exp);
        end
    endtask

    // Edge-count model: bank k is released at edge SW*(k+1); a grant may
    // happen at any edge once PW+RW+1 edges have passed since the last one.
    task automatic model_step(input int i);
        int rel;
        int g;
        int rw;
        logic [NB-1:0] s;
        rw = rw_of(i);
        if (!rn[i]) begin
            t_m[i] = 0; ptr_m[i] = 0; has_m[i] = 0; next_ok[i] = SW * NB + 1;
            if (i == 0) q_a.delete(); else q_b.delete();
            exp_setn[i] = '0; exp_busy[i] = 1'b1; exp_done[i] = 1'b0;
            return;
        end
        t_m[i]++;
        if (t_m[i] >= next_ok[i] && req[i] != '0) begin
            g = -1;
            for (int k = 0; k < NB; k++) begin
                if (g < 0 && req[i][(ptr_m[i] + k) % NB]) g = (ptr_m[i] + k) % NB;
            end
            has_m[i]   = 1'b1;
            g_m[i]     = g;
            tg_m[i]    = t_m[i];
            ptr_m[i]   = (g + 1) % NB;
            next_ok[i] = t_m[i] + PW + rw + 1;
            mgnts[i]++;
            if (i == 0) q_a.push_back(g); else q_b.push_back(g);
        end
        rel = t_m[i] / SW;
        if (rel > NB) rel = NB;
        s = '0;
        for (int k = 0; k < rel; k++) s[k] = 1'b1;
        if (has_m[i] && t_m[i] < tg_m[i] + PW) s[g_m[i]] = 1'b0;
        exp_setn[i] = s;
        exp_done[i] = has_m[i] && (t_m[i] == tg_m[i] + PW + rw - 1);
        exp_busy[i] = (t_m[i] < SW * NB) || (has_m[i] && t_m[i] < tg_m[i] + PW + rw);
    endtask

    task automatic monitor_step(input int i);
        bit have;
        int e;
        logic [NB-1:0] eg;
        chk("setn", i, 32'(setn_o[i]), 32'(exp_setn[i]));
        chk("busy", i, 32'(busy_o[i]), 32'(exp_busy[i]));
        chk("done", i, 32'(done_o[i]), 32'(exp_done[i]));
        if (rn[i] && t_m[i] >= SW * NB) begin
            chk("one_low", i, 32'($countones(~setn_o[i]) <= 1), 32'd1);
        end
        have = (i == 0) ? (q_a.size() > 0) : (q_b.size() > 0);
        if (gnt_o[i] != '0 || have) begin
            if (!have) begin
                chk("gnt_unexpected", i, 32'(gnt_o[i]), 32'd0);
            end else begin
                if (i == 0) e = q_a.pop_front(); else e = q_b.pop_front();
                eg = '0;
                eg[e] = 1'b1;
                chk("gnt", i, 32'(gnt_o[i]), 32'(eg));
            end
        end
        if (done_o[i]) dones[i]++;
        if (gnt_o[i] != '0) gnts[i]++;
        if (i == 0 && gnt_o[0][1]) b1_gnts++;
    endtask

    task automatic wait_gnt(input int i, input logic [NB-1:0] m, input int maxc);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < maxc && !ok; c++) begin
            @(posedge clk); #2;
            if ((gnt_o[i] & m) != '0) ok = 1'b1;
        end
        chk("wait_gnt", i, 32'(ok), 32'd1);
    endtask

    task automatic wait_idle(input int i, input int maxc);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < maxc && !ok; c++) begin
            @(posedge clk); #2;
            if (!busy_o[i]) ok = 1'b1;
        end
        chk("wait_idle", i, 32'(ok), 32'd1);
    endtask

    initial begin
        int g0, d0, b1;
        rn = 2'b00; mode = 2'b00;
        dir_req[0] = '0; dir_req[1] = '0;
        req[0] = '0; req[1] = '0;
        for (int i = 0; i < 2; i++) begin
            gnts[i] = 0; dones[i] = 0; mgnts[i] = 0;
        end
        b1_gnts = 0;

        fork
            forever begin
                @(posedge clk);
                for (int i = 0; i < 2; i++) model_step(i);
            end
            forever begin
                @(negedge clk);
                for (int i = 0; i < 2; i++) monitor_step(i);
            end
            begin : drv
                logic [NB-1:0] r;
                forever begin
                    @(negedge clk);
                    for (int i = 0; i < 2; i++) begin
                        if (!mode[i]) begin
                            req[i] = dir_req[i];
                        end else begin
                            r = req[i];
                            for (int b = 0; b < NB; b++) begin
                                if (r[b]) begin
                                    if (gnt_o[i][b] || $urandom_range(15) == 0) r[b] = 1'b0;
                                end else if ($urandom_range(3) == 0) begin
                                    r[b] = 1'b1;
                                end
                            end
                            req[i] = r;
                        end
                    end
                end
            end
            begin
                #200000;
                $display("FAIL watchdog: simulation did not finish");
                $fatal(1);
            end
        join_none

        // reset state
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_setn", i, 32'(setn_o[i]), 32'd0);
            chk("reset_busy", i, 32'(busy_o[i]), 32'd1);
            chk("reset_gnt", i, 32'(gnt_o[i]), 32'd0);
        end
        rn = 2'b11;
        wait_idle(0, 30);
        wait_idle(1, 30);

        // single request on A, held request on B (RW=0 repeat)
        dir_req[0] = 4'b0100;
        dir_req[1] = 4'b0001;
        wait_gnt(0, 4'b0100, 10);
        dir_req[0] = '0;
        wait_idle(0, 20);

        // contention on A
        dir_req[0] = 4'b1111;
        repeat (40) @(posedge clk);
        #2;
        dir_req[0] = '0;
        dir_req[1] = '0;
        wait_idle(0, 20);
        wait_idle(1, 20);

        // withdrawal of bank 1 during bank 0's pulse
        g0 = gnts[0]; d0 = dones[0]; b1 = b1_gnts;
        dir_req[0] = 4'b0001;
        wait_gnt(0, 4'b0001, 10);
        dir_req[0] = 4'b0010;
        repeat (2) @(posedge clk);
        #2;
        dir_req[0] = '0;
        wait_idle(0, 20);
        repeat (2) @(posedge clk);
        chk("withdraw_b1", 0, 32'(b1_gnts - b1), 32'd0);
        chk("withdraw_gnts", 0, 32'(gnts[0] - g0), 32'd1);
        chk("done_vs_gnt", 0, 32'(dones[0] - d0), 32'(gnts[0] - g0));

        // asynchronous reset during bank 2's pulse
        dir_req[0] = 4'b0100;
        wait_gnt(0, 4'b0100, 10);
        dir_req[0] = '0;
        @(negedge clk); #1;
        rn[0] = 1'b0;
        #1;
        chk("async_setn", 0, 32'(setn_o[0]), 32'd0);
        chk("async_busy", 0, 32'(busy_o[0]), 32'd1);
        repeat (2) @(negedge clk);
        rn[0] = 1'b1;
        wait_idle(0, 30);

        // randomized traffic with one random reset on A
        mode = 2'b11;
        repeat (200) @(posedge clk);
        @(negedge clk); #1;
        rn[0] = 1'b0;
        repeat ($urandom_range(3, 1)) @(negedge clk);
        rn[0] = 1'b1;
        repeat (250) @(posedge clk);
        #2;
        mode = 2'b00;
        wait_idle(0, 30);
        wait_idle(1, 30);
        repeat (3) @(posedge clk);

        for (int i = 0; i < 2; i++) begin
            chk("gnt_total", i, 32'(gnts[i]), 32'(mgnts[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
